// File: rtl/ram_okuma_denetleyici.sv
// ram_okuma_denetleyici
// Burst read controller for the read port of a synchronous dual-port RAM.
// A start command (basla) with a base address and a word count launches a
// burst. The block drives the RAM read signals, captures each returned word
// into a 2-entry output buffer, and streams the words out on a valid/ready
// interface at up to one word per clock with full backpressure.
//
// Ports
//   clk, rst_n           clock (also the RAM read clock), async active-low reset
//   basla                start strobe, sampled only while idle
//   baslangic_addr       burst base address
//   uzunluk              burst length in words (0 = no reads, just bitti)
//   mesgul               burst in progress
//   bitti                one-cycle completion pulse
//   ram_oku_addr/cs/oe   RAM read address and strobes (registered)
//   ram_we               RAM write enable, tied low
//   ram_oku_data         RAM read data
//   cikis_data/valid     output stream head
//   cikis_ready          output stream backpressure
//
// State  | meaning
// -------+------------------------------------------
// BOSTA  | idle, waiting for basla
// OKU    | reads remain to be issued
// BOSALT | all reads issued, draining buffer/in-flight
module ram_okuma_denetleyici #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  basla,
  input  logic [ADDR_WIDTH-1:0] baslangic_addr,
  input  logic [LEN_WIDTH-1:0]  uzunluk,
  output logic                  mesgul,
  output logic                  bitti,
  output logic [ADDR_WIDTH-1:0] ram_oku_addr,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_oku_data,
  output logic [DATA_WIDTH-1:0] cikis_data,
  output logic                  cikis_valid,
  input  logic                  cikis_ready
);

  typedef enum logic [1:0] {BOSTA, OKU, BOSALT} durum_t;

  durum_t                durum;
  logic [ADDR_WIDTH-1:0] isaretci;
  logic [LEN_WIDTH-1:0]  kalan;
  logic [DATA_WIDTH-1:0] ikinci_data;
  logic                  ikinci_valid;

  logic       ucusta;
  logic       pop;
  logic       kabul;
  logic       oku;
  logic [1:0] doluluk;
  logic [2:0] tahmini;

  assign ram_we = 1'b0;

  // A read issued last cycle (ram_cs still high) returns its data this cycle.
  assign ucusta  = ram_cs;
  assign pop     = cikis_valid & cikis_ready;
  assign doluluk = {1'b0, cikis_valid} + {1'b0, ikinci_valid};
  // Occupancy after this edge's pop and capture; issuing only below 2 keeps
  // buffered + in-flight words within the 2-entry buffer.
  assign tahmini = {1'b0, doluluk} + {2'b00, ucusta} - {2'b00, pop};
  assign kabul   = (durum == BOSTA) & basla & (uzunluk != '0);
  assign oku     = (kabul | (durum == OKU)) & (tahmini < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum        <= BOSTA;
      isaretci     <= '0;
      kalan        <= '0;
      ikinci_data  <= '0;
      ikinci_valid <= 1'b0;
      cikis_data   <= '0;
      cikis_valid  <= 1'b0;
      ram_oku_addr <= '0;
      ram_cs       <= 1'b0;
      ram_oe       <= 1'b0;
      mesgul       <= 1'b0;
      bitti        <= 1'b0;
    end else begin
      bitti <= 1'b0;

      // Output buffer: cikis_* is the head entry, ikinci_* the second.
      if (pop) begin
        if (ikinci_valid) begin
          cikis_data   <= ikinci_data;
          ikinci_valid <= ucusta;
          if (ucusta) ikinci_data <= ram_oku_data;
        end else begin
          cikis_valid <= ucusta;
          if (ucusta) cikis_data <= ram_oku_data;
        end
      end else if (ucusta) begin
        if (!cikis_valid) begin
          cikis_valid <= 1'b1;
          cikis_data  <= ram_oku_data;
        end else begin
          ikinci_valid <= 1'b1;
          ikinci_data  <= ram_oku_data;
        end
      end

      ram_cs <= oku;
      ram_oe <= oku;
      if (oku) ram_oku_addr <= kabul ? baslangic_addr : isaretci;

      case (durum)
        BOSTA: begin
          if (basla) begin
            if (uzunluk == '0) begin
              bitti <= 1'b1;
            end else begin
              isaretci <= baslangic_addr + ADDR_WIDTH'(1);
              kalan    <= uzunluk - LEN_WIDTH'(1);
              durum    <= (uzunluk == LEN_WIDTH'(1)) ? BOSALT : OKU;
              mesgul   <= 1'b1;
            end
          end
        end
        OKU: begin
          if (oku) begin
            isaretci <= isaretci + ADDR_WIDTH'(1);
            kalan    <= kalan - LEN_WIDTH'(1);
            if (kalan == LEN_WIDTH'(1)) durum <= BOSALT;
          end
        end
        BOSALT: begin
          if (!ucusta && (doluluk == {1'b0, pop})) begin
            durum  <= BOSTA;
            mesgul <= 1'b0;
            bitti  <= 1'b1;
          end
        end
        default: begin
          durum  <= BOSTA;
          mesgul <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_okuma_denetleyici.sv
module tb_ram_okuma_denetleyici;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        basla = 1'b0;
  logic [3:0]  baslangic_addr = '0;
  logic [4:0]  uzunluk = '0;
  logic        mesgul, bitti;
  logic [3:0]  ram_oku_addr;
  logic        ram_cs, ram_oe, ram_we;
  logic [15:0] ram_oku_data = '0;
  logic [15:0] cikis_data;
  logic        cikis_valid;
  logic        cikis_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem [16];

  ram_okuma_denetleyici dut (
    .clk(clk), .rst_n(rst_n), .basla(basla), .baslangic_addr(baslangic_addr),
    .uzunluk(uzunluk), .mesgul(mesgul), .bitti(bitti), .ram_oku_addr(ram_oku_addr),
    .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_oku_data(ram_oku_data),
    .cikis_data(cikis_data), .cikis_valid(cikis_valid), .cikis_ready(cikis_ready)
  );

  always #5 clk = ~clk;

  // RAM read port: latches on the negedge of the issue cycle.
  always @(negedge clk) if (ram_cs && ram_oe) ram_oku_data <= mem[ram_oku_addr];

  typedef struct {
    int          addr;
    int          len;
    logic [15:0] rdy;
    int          first;
    int          last;
    int          rebasla;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] words[$];
    logic [3:0]  addrs[$];
    int iss, pops, n_bitti, first_pop, last_pop, done_c, over, holds, we_bad;
    logic prev_stall;
    logic [15:0] prev_data;
    bit full;
    string tag;
    iss = 0; pops = 0; n_bitti = 0; first_pop = -1; last_pop = -1; done_c = -1;
    over = 0; holds = 0; we_bad = 0; prev_stall = 0; prev_data = '0;
    full = (v.rdy == 16'hFFFF);
    tag = $sformatf("v%0d", idx);
    basla = 1'b1;
    baslangic_addr = 4'(v.addr);
    uzunluk = 5'(v.len);
    @(posedge clk);
    #1 basla = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      cikis_ready = v.rdy[c % 16];
      if (c == v.rebasla) begin
        basla = 1'b1; baslangic_addr = 4'd0; uzunluk = 5'd5;
      end else begin
        basla = 1'b0;
      end
      if (ram_we !== 1'b0) we_bad++;
      if (ram_cs) begin addrs.push_back(ram_oku_addr); iss++; end
      if (iss - pops > 2) over++;
      if (prev_stall && (!cikis_valid || cikis_data !== prev_data)) holds++;
      if (cikis_valid && cikis_ready) begin
        words.push_back(cikis_data);
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      prev_stall = cikis_valid && !cikis_ready;
      prev_data  = cikis_data;
      if (bitti) begin
        n_bitti++;
        if (done_c < 0) begin
          done_c = c;
          chk({tag, "_mesgul_at_bitti"}, 32'(mesgul), 0);
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    basla = 1'b0;
    cikis_ready = 1'b1;
    chk({tag, "_done_in_budget"}, 32'(done_c >= 0), 1);
    chk({tag, "_word_count"}, 32'(words.size()), 32'(v.len));
    chk({tag, "_cs_count"}, 32'(iss), 32'(v.len));
    chk({tag, "_bitti_count"}, 32'(n_bitti), 1);
    chk({tag, "_max_outstanding"}, 32'(over), 0);
    chk({tag, "_hold_while_stalled"}, 32'(holds), 0);
    chk({tag, "_we_low"}, 32'(we_bad), 0);
    if (words.size() > 0) begin
      chk({tag, "_first_word"}, 32'(words[0]), 32'(v.first));
      chk({tag, "_last_word"}, 32'(words[words.size()-1]), 32'(v.last));
    end
    for (int i = 0; i < words.size() && i < v.len; i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(words[i]), 32'(16'hA000 + ((v.addr + i) % 16)));
    for (int i = 0; i < addrs.size() && i < v.len; i++)
      chk($sformatf("%s_addr%0d", tag, i), 32'(addrs[i]), 32'((v.addr + i) % 16));
    if (full) begin
      chk({tag, "_first_latency"}, 32'(first_pop), 1);
      chk({tag, "_last_pop_cycle"}, 32'(last_pop), 32'(v.len));
      chk({tag, "_bitti_cycle"}, 32'(done_c), 32'(v.len + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cs, n_valid, n_bitti, bitti_c, n_mesgul, pops;
    for (int k = 0; k < 16; k++) mem[k] = 16'hA000 + 16'(k);

    //             addr len  rdy       first     last      rebasla
    tbl[0] = '{ 2,  4, 16'hFFFF, 'hA002, 'hA005, -1};
    tbl[1] = '{14,  4, 16'hFFFF, 'hA00E, 'hA001, -1};
    tbl[2] = '{ 0,  8, 16'hB2CD, 'hA000, 'hA007, -1};
    tbl[3] = '{ 5,  1, 16'hFFFF, 'hA005, 'hA005, -1};
    tbl[4] = '{10, 17, 16'hFFFF, 'hA00A, 'hA00A, -1};
    tbl[5] = '{ 3,  6, 16'h0F0F, 'hA003, 'hA008, -1};
    tbl[6] = '{ 0, 16, 16'h3333, 'hA000, 'hA00F, -1};
    tbl[7] = '{ 7,  3, 16'hFFFF, 'hA007, 'hA009,  1};

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mesgul", 32'(mesgul), 0);
    chk("rst_bitti", 32'(bitti), 0);
    chk("rst_cs_oe", 32'({ram_cs, ram_oe, ram_we}), 0);
    chk("rst_addr", 32'(ram_oku_addr), 0);
    chk("rst_valid", 32'(cikis_valid), 0);
    chk("rst_data", 32'(cikis_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_mesgul", 32'(mesgul), 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Zero-length command: bitti one cycle later, nothing else moves
    @(negedge clk);
    basla = 1'b1; baslangic_addr = 4'd3; uzunluk = 5'd0;
    @(posedge clk);
    #1 basla = 1'b0;
    n_cs = 0; n_valid = 0; n_bitti = 0; bitti_c = -1; n_mesgul = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ram_cs) n_cs++;
      if (cikis_valid) n_valid++;
      if (mesgul) n_mesgul++;
      if (bitti) begin n_bitti++; if (bitti_c < 0) bitti_c = c; end
    end
    chk("len0_bitti_count", 32'(n_bitti), 1);
    chk("len0_bitti_cycle", 32'(bitti_c), 0);
    chk("len0_no_cs", 32'(n_cs), 0);
    chk("len0_no_valid", 32'(n_valid), 0);
    chk("len0_no_mesgul", 32'(n_mesgul), 0);

    // Reset in the middle of a len=8 burst, after the 2nd word
    basla = 1'b1; baslangic_addr = 4'd0; uzunluk = 5'd8; cikis_ready = 1'b1;
    @(posedge clk);
    #1 basla = 1'b0;
    pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clk);
      if (cikis_valid && cikis_ready) pops++;
    end
    chk("midrst_two_words_seen", 32'(pops), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(cikis_valid), 0);
    chk("midrst_cs", 32'({ram_cs, ram_oe}), 0);
    chk("midrst_mesgul", 32'(mesgul), 0);
    chk("midrst_data", 32'(cikis_data), 0);
    n_bitti = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bitti) n_bitti++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bitti || ram_cs || cikis_valid) n_bitti++;
    end
    chk("midrst_quiet_after", 32'(n_bitti), 0);
    begin
      vec_t v;
      v = '{9, 3, 16'hFFFF, 'hA009, 'hA00B, -1};
      run_vec(v, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
